// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two
// requesters, with a single-entry response register tagged by requester ID.
// Optional statistics counters are enabled by defining ALU_SHARE_ARBITER_STATS_EN.
module alu_share_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CONTROLL_WIDTH = 4,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  // requester 0
  input  logic                      r0_valid,
  output logic                      r0_ready,
  input  logic [DATA_WIDTH-1:0]     r0_op1,
  input  logic [DATA_WIDTH-1:0]     r0_op2,
  input  logic [CONTROLL_WIDTH-1:0] r0_ctrl,
  // requester 1
  input  logic                      r1_valid,
  output logic                      r1_ready,
  input  logic [DATA_WIDTH-1:0]     r1_op1,
  input  logic [DATA_WIDTH-1:0]     r1_op2,
  input  logic [CONTROLL_WIDTH-1:0] r1_ctrl,
  // shared ALU
  output logic [DATA_WIDTH-1:0]     alu_op1,
  output logic [DATA_WIDTH-1:0]     alu_op2,
  output logic [CONTROLL_WIDTH-1:0] alu_ctrl,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic                      alu_zero,
  // response
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_id,
  output logic [DATA_WIDTH-1:0]     rsp_result,
  output logic                      rsp_zero
`ifdef ALU_SHARE_ARBITER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]      gnt_cnt0,
  output logic [CNT_WIDTH-1:0]      gnt_cnt1,
  output logic [CNT_WIDTH-1:0]      conflict_cnt
`endif
);

  // Reject degenerate widths at elaboration time.
  if (DATA_WIDTH < 1 || CONTROLL_WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_params
    $error("alu_share_arbiter: all widths must be at least 1");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic                  last_grant_q;
  logic                  gnt_valid;
  logic                  gnt_idx;
  logic                  conflict;
  logic                  can_accept;
  logic                  accept;
  logic                  rsp_id_q;
  logic [DATA_WIDTH-1:0] rsp_result_q;
  logic                  rsp_zero_q;

  // Round-robin grant: on conflict, favour the requester that did not win last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 1'b0;
    conflict  = r0_valid & r1_valid;
    if (conflict) begin
      gnt_valid = 1'b1;
      gnt_idx   = ~last_grant_q;
    end else if (r0_valid) begin
      gnt_valid = 1'b1;
      gnt_idx   = 1'b0;
    end else if (r1_valid) begin
      gnt_valid = 1'b1;
      gnt_idx   = 1'b1;
    end
  end

  // Accept when the response slot is free or being drained; never during reset.
  always_comb begin
    can_accept = (state_q == EMPTY) | rsp_ready;
    accept     = gnt_valid & can_accept & ~rst;
    r0_ready   = accept & ~gnt_idx;
    r1_ready   = accept & gnt_idx;
  end

  // Steer the granted requester onto the ALU, even while the slot is stalled.
  always_comb begin
    alu_op1  = '0;
    alu_op2  = '0;
    alu_ctrl = '0;
    if (gnt_valid) begin
      if (gnt_idx) begin
        alu_op1  = r1_op1;
        alu_op2  = r1_op2;
        alu_ctrl = r1_ctrl;
      end else begin
        alu_op1  = r0_op1;
        alu_op2  = r0_op2;
        alu_ctrl = r0_ctrl;
      end
    end
  end

  // Response slot state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Response slot next state: fill on accept, drain when consumer takes it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (accept) begin
          state_d = FULL;
        end else if (rsp_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Response payload and arbitration pointer update only on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      rsp_id_q     <= gnt_idx;
      rsp_result_q <= alu_result;
      rsp_zero_q   <= alu_zero;
      last_grant_q <= gnt_idx;
    end
  end

  assign rsp_valid  = (state_q == FULL);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;

`ifdef ALU_SHARE_ARBITER_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] gnt_cnt0_q;
  logic [CNT_WIDTH-1:0] gnt_cnt1_q;
  logic [CNT_WIDTH-1:0] conflict_cnt_q;

  // Saturating accept and conflict counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_cnt0_q     <= '0;
      gnt_cnt1_q     <= '0;
      conflict_cnt_q <= '0;
    end else if (accept) begin
      if (!gnt_idx && gnt_cnt0_q != CNT_MAX) begin
        gnt_cnt0_q <= gnt_cnt0_q + CNT_WIDTH'(1);
      end
      if (gnt_idx && gnt_cnt1_q != CNT_MAX) begin
        gnt_cnt1_q <= gnt_cnt1_q + CNT_WIDTH'(1);
      end
      if (conflict && conflict_cnt_q != CNT_MAX) begin
        conflict_cnt_q <= conflict_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign gnt_cnt0     = gnt_cnt0_q;
  assign gnt_cnt1     = gnt_cnt1_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: scoreboard bench for alu_share_arbiter with a
// behavioural ALU stand-in and a transaction-level arbitration model.
module tb_alu_share_arbiter;

  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 4;
  localparam int unsigned CNT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          r0_valid, r0_ready, r1_valid, r1_ready;
  logic [DW-1:0] r0_op1, r0_op2, r1_op1, r1_op2;
  logic [CW-1:0] r0_ctrl, r1_ctrl;
  logic [DW-1:0] alu_op1, alu_op2, alu_result;
  logic [CW-1:0] alu_ctrl;
  logic          alu_zero;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [DW-1:0] rsp_result;
`ifdef ALU_SHARE_ARBITER_STATS_EN
  logic [CNT-1:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
`endif

  alu_share_arbiter #(.DATA_WIDTH(DW), .CONTROLL_WIDTH(CW), .CNT_WIDTH(CNT)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op1(r0_op1), .r0_op2(r0_op2), .r0_ctrl(r0_ctrl),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op1(r1_op1), .r1_op2(r1_op2), .r1_ctrl(r1_ctrl),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
`ifdef ALU_SHARE_ARBITER_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT.
  function automatic logic [DW-1:0] alu_fn(input logic [CW-1:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_ctrl, alu_op1, alu_op2);
  assign alu_zero   = (alu_result == '0);

  typedef struct packed {
    logic          id;
    logic [DW-1:0] res;
    logic          zero;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Transaction-level model state.
  bit m_full;
  bit m_last;
  bit acc0, acc1;
  int s_g0, s_g1, s_cf;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= (1 << CNT) - 1) ? v : v + 1;
  endfunction

  // One clock of stimulus: predict the handshake, record expectations, advance.
  task automatic cycle();
    bit            both, any, can, acc, g;
    logic [DW-1:0] e1, e2, res;
    logic [CW-1:0] ec;
    @(negedge clk);
    acc0 = 0;
    acc1 = 0;
    if (rst) begin
      check("r0_ready_in_reset", 32'(r0_ready), 32'd0);
      check("r1_ready_in_reset", 32'(r1_ready), 32'd0);
      m_full = 0;
      m_last = 1;
      sbq.delete();
      s_g0 = 0; s_g1 = 0; s_cf = 0;
    end else begin
      both = r0_valid && r1_valid;
      any  = r0_valid || r1_valid;
      g    = both ? !m_last : (r1_valid && !r0_valid);
      can  = !m_full || rsp_ready;
      acc  = any && can;
      check("r0_ready", 32'(r0_ready), 32'(acc && !g));
      check("r1_ready", 32'(r1_ready), 32'(acc && g));
      e1 = !any ? '0 : (g ? r1_op1  : r0_op1);
      e2 = !any ? '0 : (g ? r1_op2  : r0_op2);
      ec = !any ? '0 : (g ? r1_ctrl : r0_ctrl);
      check("alu_op1", alu_op1, e1);
      check("alu_op2", alu_op2, e2);
      check("alu_ctrl", 32'(alu_ctrl), 32'(ec));
      if (acc) begin
        res = alu_fn(ec, e1, e2);
        sbq.push_back('{id: g, res: res, zero: (res == '0)});
        m_full = 1;
        m_last = g;
        acc0 = !g;
        acc1 = g;
        if (!g) s_g0 = sat_inc(s_g0); else s_g1 = sat_inc(s_g1);
        if (both) s_cf = sat_inc(s_cf);
      end else if (rsp_ready) begin
        m_full = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response the consumer takes must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_result", rsp_result, e.res);
        check("rsp_zero", 32'(rsp_zero), 32'(e.zero));
      end
    end
  end

  task automatic set_r0(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [CW-1:0] c);
    r0_valid = v; r0_op1 = a; r0_op2 = b; r0_ctrl = c;
  endtask

  task automatic set_r1(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [CW-1:0] c);
    r1_valid = v; r1_op1 = a; r1_op2 = b; r1_ctrl = c;
  endtask

  task automatic rand_r0(input logic v);
    logic [DW-1:0] a;
    a = $urandom;
    set_r0(v, a, ($urandom_range(0, 3) == 0) ? a : DW'($urandom), CW'($urandom_range(0, 5)));
  endtask

  task automatic rand_r1(input logic v);
    logic [DW-1:0] a;
    a = $urandom;
    set_r1(v, a, ($urandom_range(0, 3) == 0) ? a : DW'($urandom), CW'($urandom_range(0, 5)));
  endtask

  task automatic check_reset_values();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_zero", 32'(rsp_zero), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b0;
    set_r0(0, 0, 0, 0);
    set_r1(0, 0, 0, 0);
    @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;
    check_reset_values();

    // r0 alone: 5 + 3
    rsp_ready = 1'b1;
    set_r0(1, 32'd5, 32'd3, 4'd0);
    cycle();
    set_r0(0, 0, 0, 0);
    cycle();

    // continuous conflict alternates grants
    rand_r0(1);
    rand_r1(1);
    repeat (6) begin
      cycle();
      if (acc0) rand_r0(1);
      if (acc1) rand_r1(1);
    end
    set_r0(0, 0, 0, 0);
    set_r1(0, 0, 0, 0);
    cycle();

    // backpressure: r1 10-4 held while r0 waits
    set_r1(1, 32'd10, 32'd4, 4'd1);
    cycle();
    set_r1(0, 0, 0, 0);
    rsp_ready = 1'b0;
    set_r0(1, 32'd7, 32'd2, 4'd0);
    repeat (3) begin
      cycle();
      check("bp_rsp_result", rsp_result, 32'd6);
      check("bp_rsp_id", 32'(rsp_id), 32'd1);
    end
    rsp_ready = 1'b1;
    cycle();
    set_r0(0, 0, 0, 0);
    cycle();

    // stalled conflict keeps priority: r0 wins, stall, then r1 before r0
    rsp_ready = 1'b0;
    rand_r0(1);
    cycle();
    rand_r0(1);
    rand_r1(1);
    repeat (2) cycle();
    rsp_ready = 1'b1;
    cycle();
    check("stall_prio_r1_first", 32'(acc1), 32'd1);
    if (acc1) set_r1(0, 0, 0, 0);
    cycle();
    check("stall_prio_r0_next", 32'(acc0), 32'd1);
    set_r0(0, 0, 0, 0);
    set_r1(0, 0, 0, 0);
    cycle();

    // reset mid-operation with a pending r0 request
    rsp_ready = 1'b0;
    rand_r0(1);
    cycle();
    rand_r0(1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_reset_values();
    rand_r1(1);
    rsp_ready = 1'b1;
    cycle();
    check("post_reset_r0_first", 32'(acc0), 32'd1);
    set_r0(0, 0, 0, 0);
    if (acc1) set_r1(0, 0, 0, 0);
    cycle();
    set_r1(0, 0, 0, 0);
    cycle();

    // randomized traffic with random consumer stalls
    rand_r0(0);
    rand_r1(0);
    repeat (400) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (!r0_valid || acc0) rand_r0(logic'($urandom_range(0, 2) != 0));
      if (!r1_valid || acc1) rand_r1(logic'($urandom_range(0, 2) != 0));
    end

    // drain
    set_r0(0, 0, 0, 0);
    set_r1(0, 0, 0, 0);
    rsp_ready = 1'b1;
    repeat (3) cycle();
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);

`ifdef ALU_SHARE_ARBITER_STATS_EN
    check("gnt_cnt0", 32'(gnt_cnt0), 32'(s_g0));
    check("gnt_cnt1", 32'(gnt_cnt1), 32'(s_g1));
    check("conflict_cnt", 32'(conflict_cnt), 32'(s_cf));
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("gnt_cnt0_rst", 32'(gnt_cnt0), 32'd0);
    check("gnt_cnt1_rst", 32'(gnt_cnt1), 32'd0);
    check("conflict_cnt_rst", 32'(conflict_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
